// File: rtl/m_set_bit_iter_pkg.sv
// Package: m_set_bit_pkg
// Purpose: shared width helpers and FSM state encoding for the set-bit
//          iterator and its interface.
// Contents: idx_w()/cnt_w() width functions, state_t (ST_IDLE, ST_RUN).
package m_set_bit_pkg;

  // Index width; at least one bit so a 1-bit mask still has a legal o_idx.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Count width able to hold n itself (all-ones mask).
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/m_set_bit_iter_if.sv
// Interface: m_set_bit_iter_if
// Purpose: mask load handshake and index output handshake of the set-bit
//          iterator.
// Modports: slave  - the iterator (accepts masks, produces indices)
//           master - the producer/consumer side driving it
interface m_set_bit_iter_if
  import m_set_bit_pkg::*;
#(
  parameter int INPUT_SIZE = 42
);
  localparam int IDX_W = idx_w(INPUT_SIZE);
  localparam int CNT_W = cnt_w(INPUT_SIZE);

  logic                  i_load_valid;
  logic                  o_load_ready;
  logic [INPUT_SIZE-1:0] i_data;
  logic                  o_idx_valid;
  logic                  i_idx_ready;
  logic [IDX_W-1:0]      o_idx;
  logic                  o_idx_last;
  logic [CNT_W-1:0]      o_remaining;
  logic                  o_done;

  modport slave (
    input  i_load_valid, i_data, i_idx_ready,
    output o_load_ready, o_idx_valid, o_idx, o_idx_last, o_remaining, o_done
  );

  modport master (
    output i_load_valid, i_data, i_idx_ready,
    input  o_load_ready, o_idx_valid, o_idx, o_idx_last, o_remaining, o_done
  );
endinterface

// File: rtl/m_count_ones.sv
// Module: m_count_ones
// Purpose: combinational population count.
// Ports: data  - input vector (WIDTH bits)
//        count - number of ones in data (CNT_W bits)
module m_count_ones #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CNT_W'(data[i]);
    end
  end
endmodule

// File: rtl/m_set_bit_iter_enc.sv
// Module: m_bit_index_enc
// Purpose: combinational priority encoder giving the lowest (MSB_FIRST=0)
//          or highest (MSB_FIRST=1) set bit index of a mask.
// Ports: mask    - vector to search
//        idx     - selected set-bit index (0 when mask is zero)
//        any_set - mask has at least one bit set
module m_bit_index_enc
  import m_set_bit_pkg::*;
#(
  parameter int INPUT_SIZE = 42,
  parameter bit MSB_FIRST  = 1'b0,
  localparam int IDX_W     = idx_w(INPUT_SIZE)
) (
  input  logic [INPUT_SIZE-1:0] mask,
  output logic [IDX_W-1:0]      idx,
  output logic                  any_set
);
  // The last matching iteration wins, so the scan direction sets priority.
  always_comb begin
    idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < INPUT_SIZE; i++) begin
        if (mask[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = INPUT_SIZE - 1; i >= 0; i--) begin
        if (mask[i]) idx = IDX_W'(i);
      end
    end
  end

  assign any_set = |mask;
endmodule

// File: rtl/m_set_bit_iter.sv
// Module: m_set_bit_iter
// Purpose: accepts a bit mask and emits the index of every set bit, one per
//          handshake, with a count of bits still to be accepted and a done
//          pulse when the mask is exhausted.
// Ports: i_clk   - system clock
//        i_rst_n - synchronous active-low reset
//        bus     - m_set_bit_iter_if.slave (load handshake, index handshake,
//                  o_remaining, o_done)
// Build option: SET_BIT_ITER_MSB_FIRST_EN - when defined, indices are emitted
//               highest first instead of lowest first.
//
// state   | meaning
// ST_IDLE | ready for a mask; zero mask stays here and pulses done
// ST_RUN  | presenting lowest/highest remaining set bit on o_idx
module m_set_bit_iter
  import m_set_bit_pkg::*;
#(
  parameter int INPUT_SIZE = 42
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  m_set_bit_iter_if.slave  bus
);
  localparam int IDX_W = idx_w(INPUT_SIZE);
  localparam int CNT_W = cnt_w(INPUT_SIZE);
`ifdef SET_BIT_ITER_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  state_t                state, state_n;
  logic [INPUT_SIZE-1:0] mask, mask_n;
  logic [CNT_W-1:0]      remaining, remaining_n;
  logic                  done, done_n;
  logic [CNT_W-1:0]      load_cnt;
  logic [IDX_W-1:0]      enc_idx;
  logic                  enc_any;
  logic                  run;

  m_count_ones #(
    .WIDTH (INPUT_SIZE),
    .CNT_W (CNT_W)
  ) u_count_ones (
    .data  (bus.i_data),
    .count (load_cnt)
  );

  m_bit_index_enc #(
    .INPUT_SIZE (INPUT_SIZE),
    .MSB_FIRST  (MSB_FIRST)
  ) u_enc (
    .mask    (mask),
    .idx     (enc_idx),
    .any_set (enc_any)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      mask      <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      mask      <= mask_n;
      remaining <= remaining_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    mask_n      = mask;
    remaining_n = remaining;
    done_n      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.i_load_valid) begin
          mask_n      = bus.i_data;
          remaining_n = load_cnt;
          if (load_cnt != '0) state_n = ST_RUN;
          else                done_n  = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.i_idx_ready) begin
          mask_n[enc_idx] = 1'b0;
          // RUN guarantees remaining >= 1, so this never wraps.
          remaining_n     = remaining - 1'b1;
          if (remaining == CNT_W'(1)) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign run              = (state == ST_RUN);
  assign bus.o_load_ready = !run;
  assign bus.o_idx_valid  = run;
  assign bus.o_idx        = (run && enc_any) ? enc_idx : '0;
  assign bus.o_idx_last   = run && (remaining == CNT_W'(1));
  assign bus.o_remaining  = remaining;
  assign bus.o_done       = done;
endmodule

// File: tb/tb_m_set_bit_iter.sv
module tb_m_set_bit_iter;
  typedef struct {
    int idx;
    int rem;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  m_set_bit_iter_if #(.INPUT_SIZE(8))  if8 ();
  m_set_bit_iter_if #(.INPUT_SIZE(42)) if42 ();

  m_set_bit_iter #(.INPUT_SIZE(8)) dut8 (
    .i_clk (clk), .i_rst_n (rst_n), .bus (if8.slave)
  );
  m_set_bit_iter #(.INPUT_SIZE(42)) dut42 (
    .i_clk (clk), .i_rst_n (rst_n), .bus (if42.slave)
  );

  int checks = 0;
  int errors = 0;
  exp_t q8[$];
  exp_t q42[$];
  int order[$];
  int mode8 = 0;
  int mode42 = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: set-bit indices in emission order, from plain bit tests.
  task automatic build_order(input logic [63:0] m, input int w);
    order.delete();
    for (int i = 0; i < w; i++) begin
      if (m[i]) begin
`ifdef SET_BIT_ITER_MSB_FIRST_EN
        order.push_front(i);
`else
        order.push_back(i);
`endif
      end
    end
  endtask

  task automatic push_exp(input logic [63:0] m, input int w, input bit to42);
    exp_t e;
    int n;
    build_order(m, w);
    n = order.size();
    for (int k = 0; k < n; k++) begin
      e.idx  = order[k];
      e.rem  = n - k;
      e.last = (k == n - 1);
      if (to42) q42.push_back(e);
      else      q8.push_back(e);
    end
  endtask

  // Ready drivers: 0 = always, 1 = random, 2 = pattern 1,0,0.
  initial begin
    int pat = 0;
    if8.i_idx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mode8)
        1:       if8.i_idx_ready = 1'($urandom_range(0, 1));
        2:       if8.i_idx_ready = (pat % 3 == 0);
        default: if8.i_idx_ready = 1'b1;
      endcase
      pat++;
    end
  end

  initial begin
    if42.i_idx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (mode42 == 1) if42.i_idx_ready = 1'($urandom_range(0, 1));
      else             if42.i_idx_ready = 1'b1;
    end
  end

  // Monitor for the 8-bit instance.
  bit exp_done8 = 0, stall8 = 0;
  logic [63:0] s_idx8, s_last8, s_rem8;
  always @(negedge clk) begin
    exp_t e;
    bit nxt;
    if (!rst_n) begin
      exp_done8 = 0;
      stall8 = 0;
    end else begin
      nxt = 0;
      chk("done8", 64'(if8.o_done), 64'(exp_done8));
      if (if8.o_idx_valid) begin
        chk("busy_load_ready8", 64'(if8.o_load_ready), 64'd0);
        if (stall8) begin
          chk("stall_idx8", 64'(if8.o_idx), s_idx8);
          chk("stall_last8", 64'(if8.o_idx_last), s_last8);
          chk("stall_rem8", 64'(if8.o_remaining), s_rem8);
        end
        if (if8.i_idx_ready) begin
          if (q8.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_idx8 got %0d expected none at %0t", if8.o_idx, $time);
          end else begin
            e = q8.pop_front();
            chk("idx8", 64'(if8.o_idx), 64'(e.idx));
            chk("rem8", 64'(if8.o_remaining), 64'(e.rem));
            chk("last8", 64'(if8.o_idx_last), 64'(e.last));
            nxt = e.last;
          end
        end
      end else begin
        chk("idle8", {60'd0, if8.o_load_ready, if8.o_idx_last, if8.o_idx},
            {60'd0, 1'b1, 1'b0, 3'd0});
        chk("idle_rem8", 64'(if8.o_remaining), 64'd0);
        if (if8.i_load_valid && if8.i_data == 8'd0) nxt = 1;
      end
      stall8  = if8.o_idx_valid && !if8.i_idx_ready;
      s_idx8  = 64'(if8.o_idx);
      s_last8 = 64'(if8.o_idx_last);
      s_rem8  = 64'(if8.o_remaining);
      exp_done8 = nxt;
    end
  end

  // Monitor for the 42-bit instance.
  bit exp_done42 = 0, stall42 = 0;
  logic [63:0] s_idx42, s_rem42;
  always @(negedge clk) begin
    exp_t e;
    bit nxt;
    if (!rst_n) begin
      exp_done42 = 0;
      stall42 = 0;
    end else begin
      nxt = 0;
      chk("done42", 64'(if42.o_done), 64'(exp_done42));
      if (if42.o_idx_valid) begin
        if (stall42) begin
          chk("stall_idx42", 64'(if42.o_idx), s_idx42);
          chk("stall_rem42", 64'(if42.o_remaining), s_rem42);
        end
        if (if42.i_idx_ready) begin
          if (q42.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_idx42 got %0d expected none at %0t", if42.o_idx, $time);
          end else begin
            e = q42.pop_front();
            chk("idx42", 64'(if42.o_idx), 64'(e.idx));
            chk("rem42", 64'(if42.o_remaining), 64'(e.rem));
            chk("last42", 64'(if42.o_idx_last), 64'(e.last));
            nxt = e.last;
          end
        end
      end else begin
        chk("idle42", {56'd0, if42.o_load_ready, if42.o_idx_last, if42.o_idx},
            {56'd0, 1'b1, 1'b0, 6'd0});
        if (if42.i_load_valid && if42.i_data == 42'd0) nxt = 1;
      end
      stall42 = if42.o_idx_valid && !if42.i_idx_ready;
      s_idx42 = 64'(if42.o_idx);
      s_rem42 = 64'(if42.o_remaining);
      exp_done42 = nxt;
    end
  end

  task automatic load8(input logic [7:0] d);
    int c = 0;
    while (!if8.o_load_ready && c < 500) begin
      @(posedge clk); #1; c++;
    end
    if (c >= 500) begin
      checks++; errors++;
      $display("FAIL load_ready8_timeout got 0 expected 1");
    end
    if8.i_data = d;
    if8.i_load_valid = 1'b1;
    push_exp(64'(d), 8, 1'b0);
    @(posedge clk); #1;
    if8.i_load_valid = 1'b0;
  endtask

  task automatic load42(input logic [41:0] d);
    int c = 0;
    while (!if42.o_load_ready && c < 500) begin
      @(posedge clk); #1; c++;
    end
    if (c >= 500) begin
      checks++; errors++;
      $display("FAIL load_ready42_timeout got 0 expected 1");
    end
    if42.i_data = d;
    if42.i_load_valid = 1'b1;
    push_exp(64'(d), 42, 1'b1);
    @(posedge clk); #1;
    if42.i_load_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit is42);
    int c = 0;
    while (c < 2000 && (is42 ? (q42.size() != 0 || !if42.o_load_ready)
                             : (q8.size() != 0 || !if8.o_load_ready))) begin
      @(posedge clk); #1; c++;
    end
    if (c >= 2000) begin
      checks++; errors++;
      $display("FAIL idle_timeout%0d got busy expected idle", is42 ? 42 : 8);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [41:0] d42;
    int c;
    if8.i_load_valid = 0;  if8.i_data = '0;
    if42.i_load_valid = 0; if42.i_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst8", {57'd0, if8.o_load_ready, if8.o_idx_valid, if8.o_idx_last, if8.o_done, if8.o_remaining},
        {57'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    chk("rst42", {54'd0, if42.o_load_ready, if42.o_idx_valid, if42.o_idx_last, if42.o_done, if42.o_remaining},
        {54'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic mask with ready held high; first index one cycle after load.
    mode8 = 0;
    load8(8'b1010_0110);
    chk("first_latency8", 64'(if8.o_idx_valid), 64'd1);
    wait_idle(0);

    load8(8'h00);
    wait_idle(0);

    mode8 = 2;
    load8(8'hFF);
    wait_idle(0);

    // Load attempts during RUN are ignored.
    mode8 = 0;
    load8(8'h30);
    if8.i_data = 8'h0F;
    if8.i_load_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if8.i_load_valid = 1'b0;
    wait_idle(0);
    load8(8'h0F);
    wait_idle(0);

    // Reset in the middle of an iteration.
    load8(8'hC3);
    c = 0;
    while (q8.size() > 3 && c < 50) begin
      @(posedge clk); #1; c++;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrun_rst8", {57'd0, if8.o_load_ready, if8.o_idx_valid, if8.o_idx_last, if8.o_done, if8.o_remaining},
        {57'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    q8.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    load8(8'h01);
    wait_idle(0);

    // Randomized masks and ready.
    mode8 = 1;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      load8(d);
    end
    wait_idle(0);

    // Wide instance: all-ones, end bits, random.
    mode42 = 0;
    load42({42{1'b1}});
    wait_idle(1);
    mode42 = 1;
    load42(42'h200_0000_0001);
    wait_idle(1);
    for (int i = 0; i < 10; i++) begin
      d42 = {10'($urandom), 32'($urandom)};
      if (i == 3) d42 = '0;
      load42(d42);
    end
    wait_idle(1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
